// File: rtl/imm_encoder.sv
// Immediate-field encoder: inserts an immediate into an instruction template, flagging values too wide for the field.
// Optional macro IMM_ENCODER_EXPAND_EN turns non-fitting requests into an LLB/LHB/instruction three-word expansion.
module imm_encoder #(
  parameter logic [3:0] LLB_OP      = 4'hA,
  parameter logic [3:0] LHB_OP      = 4'hB,
  parameter logic [3:0] SCRATCH_REG = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        In_Valid,
  output logic        In_Ready,
  input  logic [15:0] Value,
  input  logic [15:0] Template,
  input  logic        SignExt,
  input  logic        NineBits,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [15:0] Out_Instr,
  output logic        Fit_Err
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    EMIT_LLB   = 2'd1,
    EMIT_LHB   = 2'd2,
    EMIT_INSTR = 2'd3
  } state_t;

  // v13 carries Value[15:3]; bit k of v13 is Value[k+3].
  function automatic logic fits_field(input logic [12:0] v13, input logic se, input logic nb);
    logic ok;
    if (se && nb) begin
      ok = (v13[12:5] == {8{v13[5]}});
    end else if (se) begin
      ok = (v13 == {13{v13[0]}});
    end else begin
      ok = (v13[12:1] == 12'h000);
    end
    return ok;
  endfunction

  // t12 carries Template[15:4]; the low nibble is always replaced.
  function automatic logic [15:0] insert_field(input logic [11:0] t12, input logic [8:0] v9,
                                               input logic se, input logic nb);
    logic [15:0] r;
    if (se && nb) begin
      r = {t12[11:5], v9};
    end else begin
      r = {t12, v9[3:0]};
    end
    return r;
  endfunction

  function automatic logic [15:0] zero_field(input logic [11:0] t12, input logic se, input logic nb);
    logic [15:0] r;
    if (se && nb) begin
      r = {t12[11:5], 9'h000};
    end else begin
      r = {t12, 4'h0};
    end
    return r;
  endfunction

  state_t      state_r, state_nxt;
  logic        out_valid_r, valid_nxt;
  logic [15:0] out_instr_r, instr_nxt;
  logic        fit_err_r, fit_err_nxt;
  logic [7:0]  value_hi_r, value_hi_nxt;
  logic [11:0] template_hi_r, template_hi_nxt;
  logic        sign_ext_r, sign_ext_nxt;
  logic        nine_bits_r, nine_bits_nxt;

  logic in_ready_s;
  logic accept_s;
  logic handshake_s;
  logic fits_s;
  logic unused_s;

  assign in_ready_s  = !rst && (state_r == IDLE) && (!out_valid_r || Out_Ready);
  assign accept_s    = In_Valid && in_ready_s;
  assign handshake_s = out_valid_r && Out_Ready;
  assign fits_s      = fits_field(Value[15:3], SignExt, NineBits);
  // Template[3:0] is always overwritten, and LLB_OP only matters in the expanding build.
  assign unused_s    = &{1'b0, Template[3:0], LLB_OP};

  assign In_Ready  = in_ready_s;
  assign Out_Valid = out_valid_r;
  assign Out_Instr = out_instr_r;
  assign Fit_Err   = fit_err_r;

  // Next-state and next-output logic.
  always_comb begin
    state_nxt       = state_r;
    valid_nxt       = out_valid_r;
    instr_nxt       = out_instr_r;
    fit_err_nxt     = 1'b0;
    value_hi_nxt    = value_hi_r;
    template_hi_nxt = template_hi_r;
    sign_ext_nxt    = sign_ext_r;
    nine_bits_nxt   = nine_bits_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          value_hi_nxt    = Value[15:8];
          template_hi_nxt = Template[15:4];
          sign_ext_nxt    = SignExt;
          nine_bits_nxt   = NineBits;
          fit_err_nxt     = !fits_s;
          valid_nxt       = 1'b1;
`ifdef IMM_ENCODER_EXPAND_EN
          if (fits_s) begin
            instr_nxt = insert_field(Template[15:4], Value[8:0], SignExt, NineBits);
          end else begin
            instr_nxt = {LLB_OP, SCRATCH_REG, Value[7:0]};
            state_nxt = EMIT_LLB;
          end
`else
          instr_nxt = insert_field(Template[15:4], Value[8:0], SignExt, NineBits);
`endif
        end else if (handshake_s) begin
          valid_nxt = 1'b0;
        end else begin
          valid_nxt = out_valid_r;
        end
      end
      EMIT_LLB: begin
        if (handshake_s) begin
          instr_nxt = {LHB_OP, SCRATCH_REG, value_hi_r};
          state_nxt = EMIT_LHB;
        end else begin
          state_nxt = EMIT_LLB;
        end
      end
      EMIT_LHB: begin
        if (handshake_s) begin
          instr_nxt = zero_field(template_hi_r, sign_ext_r, nine_bits_r);
          state_nxt = EMIT_INSTR;
        end else begin
          state_nxt = EMIT_LHB;
        end
      end
      EMIT_INSTR: begin
        if (handshake_s) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end else begin
          state_nxt = EMIT_INSTR;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // State, output and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      out_valid_r   <= 1'b0;
      out_instr_r   <= 16'h0000;
      fit_err_r     <= 1'b0;
      value_hi_r    <= 8'h00;
      template_hi_r <= 12'h000;
      sign_ext_r    <= 1'b0;
      nine_bits_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      out_valid_r   <= valid_nxt;
      out_instr_r   <= instr_nxt;
      fit_err_r     <= fit_err_nxt;
      value_hi_r    <= value_hi_nxt;
      template_hi_r <= template_hi_nxt;
      sign_ext_r    <= sign_ext_nxt;
      nine_bits_r   <= nine_bits_nxt;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: table of fitting vectors issued back-to-back, plus hand sequences
// for reset, stalls, truncation and (when IMM_ENCODER_EXPAND_EN is defined) the three-word expansion.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] Value;
  logic [15:0] Template;
  logic        SignExt;
  logic        NineBits;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Out_Instr;
  logic        Fit_Err;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] value;
    logic [15:0] tmpl;
    logic        se;
    logic        nb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  imm_encoder dut (
    .clk(clk), .rst(rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Value(Value), .Template(Template), .SignExt(SignExt), .NineBits(NineBits),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Instr(Out_Instr), .Fit_Err(Fit_Err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] v, input logic [15:0] t, input logic se, input logic nb);
    In_Valid = 1'b1;
    Value    = v;
    Template = t;
    SignExt  = se;
    NineBits = nb;
  endtask

  // Drop the request, drain the output and leave the inputs scrambled.
  task automatic settle();
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    Value     = 16'hDEAD;
    Template  = 16'hBEEF;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{value: 16'hFF00, tmpl: 16'hD000, se: 1'b1, nb: 1'b1, exp: 16'hD100};
    vecs[1] = '{value: 16'h0007, tmpl: 16'h1230, se: 1'b0, nb: 1'b0, exp: 16'h1237};
    vecs[2] = '{value: 16'h000F, tmpl: 16'hFFF0, se: 1'b0, nb: 1'b0, exp: 16'hFFFF};
    vecs[3] = '{value: 16'h0000, tmpl: 16'hABCF, se: 1'b0, nb: 1'b1, exp: 16'hABC0};
    vecs[4] = '{value: 16'h00FF, tmpl: 16'h0000, se: 1'b1, nb: 1'b1, exp: 16'h00FF};
    vecs[5] = '{value: 16'hFFFF, tmpl: 16'h1200, se: 1'b1, nb: 1'b1, exp: 16'h13FF};
    vecs[6] = '{value: 16'hFFF8, tmpl: 16'h7770, se: 1'b1, nb: 1'b0, exp: 16'h7778};
    vecs[7] = '{value: 16'h0007, tmpl: 16'h555F, se: 1'b1, nb: 1'b0, exp: 16'h5557};
    vecs[8] = '{value: 16'hFF80, tmpl: 16'h2000, se: 1'b1, nb: 1'b1, exp: 16'h2180};
    vecs[9] = '{value: 16'h0005, tmpl: 16'h1234, se: 1'b0, nb: 1'b1, exp: 16'h1235};

    // Reset with a request pending: it must not be taken.
    rst = 1'b1;
    Out_Ready = 1'b1;
    drive(16'h0001, 16'h1110, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", In_Ready, 16'h0);
      chk("rst_out_valid", Out_Valid, 16'h0);
      chk("rst_out_instr", Out_Instr, 16'h0000);
      chk("rst_fit_err", Fit_Err, 16'h0);
    end
    rst = 1'b0;
    In_Valid = 1'b0;
    @(negedge clk);
    chk("post_rst_no_accept", Out_Valid, 16'h0);
    chk("post_rst_in_ready", In_Ready, 16'h1);

    // Fitting vectors back to back: one word per cycle, In_Ready never drops.
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        chk("tbl_valid", Out_Valid, 16'h1);
        chk("tbl_instr", Out_Instr, vecs[i-1].exp);
        chk("tbl_fit_err", Fit_Err, 16'h0);
      end
      chk("tbl_in_ready", In_Ready, 16'h1);
      drive(vecs[i].value, vecs[i].tmpl, vecs[i].se, vecs[i].nb);
      @(negedge clk);
    end
    chk("tbl_valid", Out_Valid, 16'h1);
    chk("tbl_instr", Out_Instr, vecs[9].exp);
    chk("tbl_fit_err", Fit_Err, 16'h0);
    settle();
    chk("tbl_drained", Out_Valid, 16'h0);

    // Stall: word held stable, no new acceptance, inputs may change.
    Out_Ready = 1'b0;
    drive(16'h0007, 16'h1230, 1'b0, 1'b0);
    @(negedge clk);
    drive(16'h00FF, 16'hFFFF, 1'b1, 1'b1);
    repeat (3) begin
      chk("stall_valid", Out_Valid, 16'h1);
      chk("stall_instr", Out_Instr, 16'h1237);
      chk("stall_in_ready", In_Ready, 16'h0);
      @(negedge clk);
    end
    In_Valid = 1'b0;
    Out_Ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", Out_Valid, 16'h0);
    chk("stall_release_in_ready", In_Ready, 16'h1);
    settle();

    // Reset while a word is held.
    Out_Ready = 1'b0;
    drive(16'h0003, 16'h8880, 1'b0, 1'b0);
    @(negedge clk);
    In_Valid = 1'b0;
    chk("hold_instr", Out_Instr, 16'h8883);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", Out_Valid, 16'h0);
    chk("midrst_instr", Out_Instr, 16'h0000);
    chk("midrst_in_ready", In_Ready, 16'h0);
    rst = 1'b0;
    settle();

`ifdef IMM_ENCODER_EXPAND_EN
    // Non-fitting value expands into LLB, LHB, then the zero-field instruction.
    drive(16'h0008, 16'h4560, 1'b1, 1'b0);
    @(negedge clk);
    drive(16'hFFFF, 16'h0000, 1'b0, 1'b0);
    In_Valid = 1'b0;
    chk("exp_llb", Out_Instr, 16'hAF08);
    chk("exp_llb_valid", Out_Valid, 16'h1);
    chk("exp_fit_err", Fit_Err, 16'h1);
    chk("exp_in_ready", In_Ready, 16'h0);
    @(negedge clk);
    chk("exp_lhb", Out_Instr, 16'hBF00);
    chk("exp_fit_err_once", Fit_Err, 16'h0);
    chk("exp_in_ready", In_Ready, 16'h0);
    @(negedge clk);
    chk("exp_instr", Out_Instr, 16'h4560);
    chk("exp_instr_valid", Out_Valid, 16'h1);
    @(negedge clk);
    chk("exp_done_valid", Out_Valid, 16'h0);
    chk("exp_done_in_ready", In_Ready, 16'h1);
    settle();

    // Reset while the LHB word is presented abandons the sequence.
    drive(16'h0008, 16'h4560, 1'b1, 1'b0);
    @(negedge clk);
    In_Valid = 1'b0;
    chk("exp2_llb", Out_Instr, 16'hAF08);
    @(negedge clk);
    chk("exp2_lhb", Out_Instr, 16'hBF00);
    rst = 1'b1;
    @(negedge clk);
    chk("exp2_rst_valid", Out_Valid, 16'h0);
    chk("exp2_rst_instr", Out_Instr, 16'h0000);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("exp2_abandoned", Out_Valid, 16'h0);
    end
    settle();
`else
    // Non-fitting value truncated into the field, Fit_Err pulses even while stalled.
    Out_Ready = 1'b0;
    drive(16'h0008, 16'h4560, 1'b1, 1'b0);
    @(negedge clk);
    In_Valid = 1'b0;
    chk("trunc_valid", Out_Valid, 16'h1);
    chk("trunc_instr", Out_Instr, 16'h4568);
    chk("trunc_fit_err", Fit_Err, 16'h1);
    @(negedge clk);
    chk("trunc_fit_err_once", Fit_Err, 16'h0);
    chk("trunc_hold", Out_Instr, 16'h4568);
    chk("trunc_in_ready", In_Ready, 16'h0);
    Out_Ready = 1'b1;
    @(negedge clk);
    chk("trunc_release", Out_Valid, 16'h0);
    settle();

    drive(16'h1234, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    drive(16'h0100, 16'hFE00, 1'b1, 1'b1);
    chk("trunc_u_instr", Out_Instr, 16'h0004);
    chk("trunc_u_fit_err", Fit_Err, 16'h1);
    @(negedge clk);
    In_Valid = 1'b0;
    chk("trunc_s9_instr", Out_Instr, 16'hFF00);
    chk("trunc_s9_fit_err", Fit_Err, 16'h1);
    @(negedge clk);
    chk("trunc_s9_clear", Fit_Err, 16'h0);
    settle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
